// File: rtl/car_pkg.sv
// Shared state encoding for the car start sequencer and its sensor channels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package car_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    LOCKED   = 3'd1,
    SELFTEST = 3'd2,
    READY    = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_e;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: unsigned window compare plus run-length debounce of the warning.
// Latency: warn follows a stable change of the out-of-range condition after DEBOUNCE cycles.
// Backpressure: none; samples every cycle.
// Optional macro CSC_WARN_LATCH_EN: a set warning stays set until rst or clr.
// Ports: clk/rst (sync, active-high), clr (drop a latched warning), val/lo/hi (inclusive window), warn.
module sensor_debounce
  import car_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] val,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              warn
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic             oor;
  logic             oor_q, oor_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             warn_q, warn_d;

  always_comb begin
    // lo > hi makes both halves of the window test overlap, so the channel is always flagged.
    oor   = (val < lo) | (val > hi);
    oor_d = oor;
    // Length of the current run of identical oor samples, this cycle included.
    if (oor != oor_q) begin
      run_d = CNT_W'(1);
    end else if (run_q == CNT_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + CNT_W'(1);
    end
`ifdef CSC_WARN_LATCH_EN
    if (clr) begin
      warn_d = 1'b0;
    end else if ((run_d == CNT_MAX) && oor) begin
      warn_d = 1'b1;
    end else begin
      warn_d = warn_q;
    end
`else
    warn_d = (run_d == CNT_MAX) ? oor : warn_q;
`endif
  end

`ifndef CSC_WARN_LATCH_EN
  logic unused_clr;
  assign unused_clr = clr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q  <= 1'b0;
      run_q  <= '0;
      warn_q <= 1'b0;
    end else begin
      oor_q  <= oor_d;
      run_q  <= run_d;
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;

endmodule

// File: rtl/car_start_sequencer.sv
// Start supervision: PIN entry with retry lockout, self-test dwell, READY/RUN/FAULT on debounced sensors.
// Latency: all outputs registered, changing on the edge that enters a state; warnings lag inputs by DEBOUNCE.
// Backpressure: none; pin_valid is a one-cycle strobe, ignored outside IDLE.
// Optional macro CSC_WARN_LATCH_EN: sensor warnings are sticky until rst or a stop back to IDLE.
// Ports: clk/rst (sync, active-high); pin_valid/pin_in; sensor_val/lo/hi packed NUM_CH x DATA_W;
//        seatbelt, airbag, start_req, stop_req; warn, key, readytogo, running, locked, tries_left, state.
module car_start_sequencer
  import car_pkg::*;
#(
  parameter int NUM_CH          = 8,
  parameter int DATA_W          = 16,
  parameter int PIN_W           = 16,
  parameter int PIN_CODE        = 9999,
  parameter int MAX_TRIES       = 3,
  parameter int LOCK_CYCLES     = 1000,
  parameter int DEBOUNCE        = 4,
  parameter int SELFTEST_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pin_valid,
  input  logic [PIN_W-1:0]             pin_in,
  input  logic [NUM_CH*DATA_W-1:0]     sensor_val,
  input  logic [NUM_CH*DATA_W-1:0]     sensor_lo,
  input  logic [NUM_CH*DATA_W-1:0]     sensor_hi,
  input  logic                         seatbelt,
  input  logic                         airbag,
  input  logic                         start_req,
  input  logic                         stop_req,
  output logic [NUM_CH-1:0]            warn,
  output logic                         key,
  output logic                         readytogo,
  output logic                         running,
  output logic                         locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [STATE_W-1:0]           state
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int ST_W  = $clog2(SELFTEST_CYCLES + 1);

  state_e           state_q, state_d;
  logic             key_q, key_d;
  logic             ready_q, ready_d;
  logic             running_q, running_d;
  logic             locked_q, locked_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [ST_W-1:0]  st_cnt_q, st_cnt_d;

  logic in_session;
  logic warn_clr;
  logic ok;

  // Session states are the ones stop_req can abort.
  assign in_session = (state_q == SELFTEST) || (state_q == READY) ||
                      (state_q == RUN)      || (state_q == FAULT);
  assign warn_clr   = in_session && stop_req;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_debounce #(
      .DATA_W   (DATA_W),
      .DEBOUNCE (DEBOUNCE)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .clr  (warn_clr),
      .val  (sensor_val[i*DATA_W +: DATA_W]),
      .lo   (sensor_lo[i*DATA_W +: DATA_W]),
      .hi   (sensor_hi[i*DATA_W +: DATA_W]),
      .warn (warn[i])
    );
  end

  assign ok = (warn == '0) && seatbelt && airbag;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    ready_d    = ready_q;
    running_d  = running_q;
    locked_d   = locked_q;
    tries_d    = tries_q;
    lock_cnt_d = lock_cnt_q;
    st_cnt_d   = st_cnt_q;

    if (in_session && stop_req) begin
      state_d   = IDLE;
      key_d     = 1'b0;
      ready_d   = 1'b0;
      running_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pin_valid) begin
            if (pin_in == PIN_W'(PIN_CODE)) begin
              state_d  = SELFTEST;
              key_d    = 1'b1;
              tries_d  = TRY_W'(MAX_TRIES);
              st_cnt_d = '0;
            end else if (tries_q <= TRY_W'(1)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              tries_d    = '0;
              lock_cnt_d = LCK_W'(LOCK_CYCLES);
            end else begin
              tries_d = tries_q - TRY_W'(1);
            end
          end
        end
        LOCKED: begin
          // Leaving on the edge where the counter would hit 0 gives exactly LOCK_CYCLES cycles here.
          if (lock_cnt_q <= LCK_W'(1)) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            tries_d    = TRY_W'(MAX_TRIES);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q - LCK_W'(1);
          end
        end
        SELFTEST: begin
          if (st_cnt_q == ST_W'(SELFTEST_CYCLES - 1)) begin
            st_cnt_d = '0;
            state_d  = ok ? READY : FAULT;
            ready_d  = ok;
          end else begin
            st_cnt_d = st_cnt_q + ST_W'(1);
          end
        end
        READY: begin
          if (!ok) begin
            state_d = FAULT;
            ready_d = 1'b0;
          end else if (start_req) begin
            state_d   = RUN;
            running_d = 1'b1;
          end
        end
        RUN: begin
          if (!ok) begin
            state_d   = FAULT;
            ready_d   = 1'b0;
            running_d = 1'b0;
          end
        end
        FAULT: begin
          if (ok) begin
            state_d = READY;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          key_d     = 1'b0;
          ready_d   = 1'b0;
          running_d = 1'b0;
          locked_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 1'b0;
      ready_q    <= 1'b0;
      running_q  <= 1'b0;
      locked_q   <= 1'b0;
      tries_q    <= TRY_W'(MAX_TRIES);
      lock_cnt_q <= '0;
      st_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      ready_q    <= ready_d;
      running_q  <= running_d;
      locked_q   <= locked_d;
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
      st_cnt_q   <= st_cnt_d;
    end
  end

  assign key        = key_q;
  assign readytogo  = ready_q;
  assign running    = running_q;
  assign locked     = locked_q;
  assign tries_left = tries_q;
  assign state      = state_q;

endmodule

// File: tb/tb_car_start_sequencer.sv
// Bench for car_start_sequencer: per-cycle vector table with a queue of expected outputs.
// Each row holds inputs for a number of cycles and the outputs expected after each of those edges.
// Rows covering the sticky-warning behaviour switch on CSC_WARN_LATCH_EN.
module tb_car_start_sequencer;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     pin_valid;
  logic [15:0]              pin_in;
  logic [NUM_CH*DATA_W-1:0] sensor_val;
  logic [NUM_CH*DATA_W-1:0] sensor_lo;
  logic [NUM_CH*DATA_W-1:0] sensor_hi;
  logic                     seatbelt;
  logic                     airbag;
  logic                     start_req;
  logic                     stop_req;
  logic [NUM_CH-1:0]        warn;
  logic                     key;
  logic                     readytogo;
  logic                     running;
  logic                     locked;
  logic [1:0]               tries_left;
  logic [2:0]               state;

  car_start_sequencer #(
    .NUM_CH          (NUM_CH),
    .DATA_W          (DATA_W),
    .PIN_W           (16),
    .PIN_CODE        (9999),
    .MAX_TRIES       (3),
    .LOCK_CYCLES     (16),
    .DEBOUNCE        (4),
    .SELFTEST_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_valid  (pin_valid),
    .pin_in     (pin_in),
    .sensor_val (sensor_val),
    .sensor_lo  (sensor_lo),
    .sensor_hi  (sensor_hi),
    .seatbelt   (seatbelt),
    .airbag     (airbag),
    .start_req  (start_req),
    .stop_req   (stop_req),
    .warn       (warn),
    .key        (key),
    .readytogo  (readytogo),
    .running    (running),
    .locked     (locked),
    .tries_left (tries_left),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [15:0] pin;
    logic        belt;
    logic        start;
    logic        stop;
    logic [15:0] v2;
    logic [15:0] lo5;
    int          rep;
    logic [2:0]  st;
    logic        key;
    logic        rdy;
    logic        run;
    logic        lck;
    logic [1:0]  tries;
    logic [7:0]  warn;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic       key;
    logic       rdy;
    logic       run;
    logic       lck;
    logic [1:0] tries;
    logic [7:0] warn;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOCK = 3'd1, S_ST = 3'd2,
                         S_RDY  = 3'd3, S_RUN  = 3'd4, S_FLT = 3'd5;

  task automatic add(input logic r, input logic pv, input logic [15:0] pin,
                     input logic belt, input logic start, input logic stop,
                     input logic [15:0] v2, input logic [15:0] lo5, input int rep,
                     input logic [2:0] st, input logic k, input logic rdy,
                     input logic run, input logic lck, input logic [1:0] tries,
                     input logic [7:0] w);
    vec_t v;
    v.rst = r; v.pv = pv; v.pin = pin; v.belt = belt; v.start = start; v.stop = stop;
    v.v2 = v2; v.lo5 = lo5; v.rep = rep;
    v.st = st; v.key = k; v.rdy = rdy; v.run = run; v.lck = lck; v.tries = tries; v.warn = w;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    pin_valid  = v.pv;
    pin_in     = v.pin;
    seatbelt   = v.belt;
    airbag     = 1'b1;
    start_req  = v.start;
    stop_req   = v.stop;
    sensor_val = {NUM_CH{16'd300}};
    sensor_lo  = {NUM_CH{16'd100}};
    sensor_hi  = {NUM_CH{16'd500}};
    sensor_val[2*DATA_W +: DATA_W] = v.v2;
    sensor_lo[5*DATA_W +: DATA_W]  = v.lo5;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    // Reset state.
    add(1, 0, 0,    1, 0, 0, 300, 100, 2,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    // Correct PIN: key next cycle, 8 cycles of self-test, then READY, then RUN on start.
    add(0, 1, 9999, 1, 0, 0, 300, 100, 1,  S_ST,   1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 7,  S_ST,   1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_RDY,  1, 1, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 1, 0, 300, 100, 1,  S_RUN,  1, 1, 1, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 2,  S_RUN,  1, 1, 1, 0, 3, 8'h00);
    // Debounce: 3-cycle glitch is filtered, a 4-cycle excursion sets warn[2].
    add(0, 0, 0,    1, 0, 0, 1000, 100, 3, S_RUN,  1, 1, 1, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 4,  S_RUN,  1, 1, 1, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 1000, 100, 3, S_RUN,  1, 1, 1, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 1000, 100, 1, S_RUN,  1, 1, 1, 0, 3, 8'h04);
    add(0, 0, 0,    1, 0, 0, 1000, 100, 1, S_FLT,  1, 0, 0, 0, 3, 8'h04);
`ifdef CSC_WARN_LATCH_EN
    // Sticky warning keeps FAULT until stop.
    add(0, 0, 0,    1, 1, 0, 300, 100, 6,  S_FLT,  1, 0, 0, 0, 3, 8'h04);
    add(0, 0, 0,    1, 0, 1, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
`else
    // Back in range for 4 cycles clears warn, then FAULT returns to READY, never RUN.
    add(0, 0, 0,    1, 0, 0, 300, 100, 3,  S_FLT,  1, 0, 0, 0, 3, 8'h04);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_FLT,  1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 1, 0, 300, 100, 1,  S_RDY,  1, 1, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_RDY,  1, 1, 0, 0, 3, 8'h00);
    // stop and start together in READY: stop wins.
    add(0, 0, 0,    1, 1, 1, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
`endif
    // Wrong PIN with stop in IDLE: PIN still processed. Then lockout.
    add(0, 1, 1816, 1, 0, 1, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 2, 8'h00);
    add(0, 1, 1816, 1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 1, 8'h00);
    add(0, 1, 1816, 1, 0, 0, 300, 100, 1,  S_LOCK, 0, 0, 0, 1, 0, 8'h00);
    add(0, 1, 9999, 1, 0, 1, 300, 100, 1,  S_LOCK, 0, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 14, S_LOCK, 0, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    // Seatbelt open at the end of self-test, then fastened.
    add(0, 1, 9999, 1, 0, 0, 300, 100, 1,  S_ST,   1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 6,  S_ST,   1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    0, 0, 0, 300, 100, 1,  S_ST,   1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    0, 0, 0, 300, 100, 1,  S_FLT,  1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_RDY,  1, 1, 0, 0, 3, 8'h00);
    // !ok alongside start in READY goes to FAULT.
    add(0, 0, 0,    0, 1, 0, 300, 100, 1,  S_FLT,  1, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_RDY,  1, 1, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 1, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    // Lock again, then reset mid-lock.
    add(0, 1, 1,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 2, 8'h00);
    add(0, 1, 2,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 1, 8'h00);
    add(0, 1, 3,    1, 0, 0, 300, 100, 1,  S_LOCK, 0, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 5,  S_LOCK, 0, 0, 0, 1, 0, 8'h00);
    add(1, 0, 0,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 100, 20, S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    // lo > hi on channel 5: always out of range.
    add(0, 0, 0,    1, 0, 0, 300, 600, 3,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
    add(0, 0, 0,    1, 0, 0, 300, 600, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h20);
    add(0, 0, 0,    1, 0, 0, 300, 100, 3,  S_IDLE, 0, 0, 0, 0, 3, 8'h20);
`ifdef CSC_WARN_LATCH_EN
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h20);
`else
    add(0, 0, 0,    1, 0, 0, 300, 100, 1,  S_IDLE, 0, 0, 0, 0, 3, 8'h00);
`endif

    drive(tbl[0]);
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        drive(tbl[i]);
        e.st = tbl[i].st; e.key = tbl[i].key; e.rdy = tbl[i].rdy; e.run = tbl[i].run;
        e.lck = tbl[i].lck; e.tries = tbl[i].tries; e.warn = tbl[i].warn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got.st = state; got.key = key; got.rdy = readytogo; got.run = running;
        got.lck = locked; got.tries = tries_left; got.warn = warn;
        e = exp_q.pop_front();
        chk("state",      i, int'(got.st),    int'(e.st));
        chk("key",        i, int'(got.key),   int'(e.key));
        chk("readytogo",  i, int'(got.rdy),   int'(e.rdy));
        chk("running",    i, int'(got.run),   int'(e.run));
        chk("locked",     i, int'(got.lck),   int'(e.lck));
        chk("tries_left", i, int'(got.tries), int'(e.tries));
        chk("warn",       i, int'(got.warn),  int'(e.warn));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
